// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared 1-bit full adder walks WIDTH operand bits LSB first,
// with valid/ready handshakes on the operand and result sides.

module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             fa_s, fa_co;
    logic [WIDTH:0]   sum_ext;

    serial_adder_fa u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Extended vector keeps the MSB-insert shift legal when WIDTH == 1.
    assign sum_ext = {fa_s, sum_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_ext[WIDTH:1];
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // Final bit holds the counter so it never wraps.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    c_out_d = fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, c_in;
    logic [7:0] a, b;
    logic       in_ready, out_valid, c_out, busy;
    logic [7:0] sum;

    logic       in_valid1, out_ready1, c_in1;
    logic [0:0] a1, b1;
    logic       in_ready1, out_valid1, c_out1, busy1;
    logic [0:0] sum1;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] sb[$];
    logic [1:0] sb1[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .busy(busy1)
    );

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        a = av; b = bv; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(9'(av) + 9'(bv) + 9'(ci));
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    endtask

    task automatic recv8(input string name, input int exp_lat, input int gap);
        int n = 0;
        logic [8:0] exp;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            if (exp_lat >= 0) begin
                vectors++;
                if (n !== exp_lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
                end
            end
            repeat (gap) begin @(posedge clk); #1; end
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL %s dup: unexpected result %h, scoreboard empty", name, {c_out, sum});
            end else begin
                exp = sb.pop_front();
                if ({c_out, sum} !== exp) begin
                    miscompares++;
                    $display("FAIL %s result: got {c_out,sum}=%h, required %h", name, {c_out, sum}, exp);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s release: got {in_ready,out_valid,busy}=%b, required 100",
                     name, {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({in_ready, busy, out_valid, c_out, sum} !== {4'b1000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_held: got %b, required 100000000000", {in_ready, busy, out_valid, c_out, sum});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, busy, out_valid, c_out, sum, in_ready1, out_valid1} !== {4'b1000, 8'h00, 2'b10}) begin
            miscompares++;
            $display("FAIL reset_release: got %b, required 10000000000010",
                     {in_ready, busy, out_valid, c_out, sum, in_ready1, out_valid1});
        end
    endtask

    task automatic test_basic();
        send8(8'h03, 8'h05, 1'b0);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        recv8("basic", 8, 0);
    endtask

    task automatic test_carry();
        send8(8'hFF, 8'h01, 1'b0); recv8("carry_ff01", 8, 0);
        send8(8'hFF, 8'hFF, 1'b1); recv8("carry_ffff1", 8, 0);
        send8(8'h00, 8'h00, 1'b0); recv8("carry_zero", 8, 0);
        send8(8'h00, 8'hFF, 1'b1); recv8("carry_00ff1", 8, 0);
    endtask

    task automatic test_backpressure();
        int n = 0;
        send8(8'h12, 8'h34, 1'b0);
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({sum, c_out, in_ready, out_valid} !== {8'h46, 3'b001}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got {sum,c_out,in_ready,out_valid}=%h/%b%b%b, required 46/001",
                         k, sum, c_out, in_ready, out_valid);
            end
            if (k == 1) begin
                a = 8'hAA; b = 8'hAA; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        recv8("bp_release", -1, 0);
        @(posedge clk); #1;
        vectors++;
        if ({busy, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_ignored: got {busy,out_valid}=%b, required 00", {busy, out_valid});
        end
    endtask

    task automatic test_reset_midrun();
        send8(8'h55, 8'h22, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, busy, out_valid, c_out, sum} !== {4'b1000, 8'h00}) begin
            miscompares++;
            $display("FAIL midrun_reset: got %b, required 100000000000", {in_ready, busy, out_valid, c_out, sum});
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_discard: got out_valid=%b, required 0", out_valid);
        end
        send8(8'h0F, 8'h01, 1'b0);
        recv8("after_reset", 8, 0);
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] exp;
        int n;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; c_in1 = v[0]; in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            sb1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            n = 0;
            while (out_valid1 !== 1'b1 && n < 10) begin
                @(posedge clk); #1; n++;
            end
            exp = sb1.pop_front();
            vectors++;
            if (n !== 1 || out_valid1 !== 1'b1 || {c_out1, sum1} !== exp) begin
                miscompares++;
                $display("FAIL w1_%0d: got {c_out,sum}=%0d lat=%0d valid=%b, required %0d lat=1 valid=1",
                         i, {c_out1, sum1}, n, out_valid1, exp);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) in_valid = 1'b1;
            recv8("random", -1, int'($urandom_range(0, 3)));
            in_valid = 1'b0;
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_empty: got %0d pending results, required 0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_midrun();
        test_width1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
